router_switch_arbiter: RTL
==========================

Name: router_switch_arbiter

Overview:
- Switch allocator for the 3-port router (x, y, local).
- Takes per-input route requests from the router algorithm (2-bit dest) and arbitrates each output between competing inputs using round-robin.
- Holds an output for a whole packet (wormhole lock, head to tail).
- Drives the 2-bit select codes of the three 4:1 output data selectors and per-input grant (pop) strobes. Replaces ad-hoc per-input decoding that let two inputs write one selector.

Parameters:
- STALL_LIMIT, 16, cycles a locked output may make no transfer before forced release; 0 disables the watchdog.
- SW, $clog2(STALL_LIMIT+1) (local), stall counter width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid_x / in_valid_y / in_valid_local  in  1 each  flit present at input
- in_dest_x / in_dest_y / in_dest_local  in  2 each  route: 00 invalid, 01 x, 10 y, 11 local
- in_tail_x / in_tail_y / in_tail_local  in  1 each  flit is last of packet
- out_ready_x / out_ready_y / out_ready_local  in  1 each  downstream can accept a flit this cycle
- in_grant_x / in_grant_y / in_grant_local  out  1 each  flit consumed this cycle; input presents next flit after the edge
- control_x / control_y / control_local  out  2 each  selector code: 00 none, 01 from x, 10 from y, 11 from local
- issue  out  3  sticky bad-dest flags [0]=x [1]=y [2]=local
- stall_err  out  3  sticky watchdog flags per output [0]=x [1]=y [2]=local

Behaviour:
- Reset, asynchronous via rst_n:
  - all owners none; control_* = 00; issue = 000; stall_err = 000; RR pointers = x; stall counters 0.
  - Grants are combinational, so they are 0 while owners are none.
- Per output o, a 2-state FSM:
  - FREE (control_o = 00), LOCKED(owner i) (control_o = code of i).
  - control_o is registered and equals the owner code.
- Grant:
  - in_grant_i = in_valid_i & (owner_o == i) & out_ready_o, where o = dest_i. Combinational, no latency once locked.
  - Bad-dest grant is defined separately below.
- Allocation, evaluated every posedge:
  - Output o is eligible when FREE, or when its owner transfers a tail this cycle (grant & tail).
  - Candidates: inputs with in_valid, in_dest == o, owning no output, and not currently transferring a tail.
  - Priority scan starts at the pointer, order x→y→local→x. The winner becomes owner and the pointer moves to the winner+1.
  - No candidate: FREE, pointer unchanged.
- Latency: head valid at cycle N, owner/control set at edge N+1, first grant in cycle N+1 (if ready). Then one flit per cycle while ready.
- Release: a tail granted in cycle K returns the output to FREE at edge K+1 (control 00), unless a new owner is allocated at the same edge.
- Single-flit packet (head = tail): lock and release in consecutive edges.
- out_ready low: no grant; owner, control and flit held.
- Bad dest 00:
  - in_grant_i = in_valid_i combinationally, so the flit is dropped and never blocks.
  - issue[i] set at the next edge and held until reset.
  - Never a candidate.
- Simultaneous heads to the same output: one winner per edge. Losers wait with valid held; no flit is lost.
- Different outputs allocate independently within the same edge.
- Watchdog (STALL_LIMIT > 0):
  - Counter per LOCKED output increments on each cycle with no grant and clears on a grant.
  - Reaching STALL_LIMIT forces FREE and sets stall_err[o], sticky.
  - The stalled input's remaining flits re-request as if they were a head.
- Reset mid-packet: immediate return to reset state; partial packets are the upstream's concern.

Decomposition:
- Shared package router_pkg:
  - Dest/select codes DIR_NONE = 2'b00, DIR_X = 2'b01, DIR_Y = 2'b10, DIR_LOCAL = 2'b11.
  - Port index constants, flit width 40.
- One sub-module rr_arbiter3: 3-bit request vector and pointer in → one-hot grant out, plus next pointer. Combinational.
- Instantiated three times, once per output. FSM, watchdog and grant logic stay in the top.

Test Plan:
- x sends 3-flit packet dest 10, ready_y=1:
  - control_y=01 from edge 1, in_grant_x high 3 cycles.
  - control_y=00 after the tail edge; issue=000.
- x and local both head dest 11 at the same cycle after reset:
  - x wins (control_local=01) and finishes its packet.
  - local then locks (control_local=11) the edge after x's tail; no overlap of grants.
- Locked y→x packet, out_ready_x low 5 cycles mid-packet:
  - in_grant_y=0 those cycles, control_x stays 10, stall_err=000.
  - Remaining flits complete after ready returns.
- in_dest_y=00 with valid: in_grant_y=1 same cycle, issue=010 next edge and stays 010 through later traffic.
- STALL_LIMIT=16, lock local→y then ready_y low 16 cycles: control_y→00, stall_err=010.
- Assert rst_n low mid-packet: all control_*=00, grants 0, flags cleared immediately; clean allocation after release.

Source files
------------

// File: rtl/router_pkg.sv
// rtl/router_pkg.sv - shared direction codes, port indices and helpers for the 3-port router
package router_pkg;

    // Destination / selector codes
    localparam logic [1:0] DIR_NONE  = 2'b00;
    localparam logic [1:0] DIR_X     = 2'b01;
    localparam logic [1:0] DIR_Y     = 2'b10;
    localparam logic [1:0] DIR_LOCAL = 2'b11;

    // Port indices
    localparam int PORT_X     = 0;
    localparam int PORT_Y     = 1;
    localparam int PORT_LOCAL = 2;
    localparam int N_PORTS    = 3;

    localparam int FLIT_W = 40;

    typedef enum logic {
        S_FREE   = 1'b0,
        S_LOCKED = 1'b1
    } out_state_e;

    // Port index 0..2 maps onto selector code 01..11
    function automatic logic [1:0] idx_to_code(input logic [1:0] idx);
        return idx + 2'd1;
    endfunction

    function automatic logic [1:0] onehot_to_code(input logic [2:0] oh);
        if (oh[0])      return DIR_X;
        else if (oh[1]) return DIR_Y;
        else if (oh[2]) return DIR_LOCAL;
        return DIR_NONE;
    endfunction

endpackage

// File: rtl/router_switch_arbiter_rr.sv
// rtl/router_switch_arbiter_rr.sv - 3-way combinational round-robin arbiter
//   i_req     : request vector [0]=x [1]=y [2]=local
//   i_ptr     : index of the highest-priority requester
//   o_gnt     : one-hot grant (zero when no request)
//   o_nxt_ptr : index after the winner (i_ptr when no request)
module rr_arbiter3
    import router_pkg::*;
(
    input  logic [2:0] i_req,
    input  logic [1:0] i_ptr,
    output logic [2:0] o_gnt,
    output logic [1:0] o_nxt_ptr
);

    int w_idx;

    // Scan from the farthest position back to the pointer so the nearest
    // requester (in x->y->local->x order) is the last to overwrite.
    always_comb begin
        o_gnt     = '0;
        o_nxt_ptr = i_ptr;
        w_idx     = 0;
        for (int k = N_PORTS - 1; k >= 0; k--) begin
            w_idx = (int'(i_ptr) + k) % N_PORTS;
            if (i_req[w_idx]) begin
                o_gnt        = '0;
                o_gnt[w_idx] = 1'b1;
                o_nxt_ptr    = 2'((w_idx + 1) % N_PORTS);
            end
        end
    end

endmodule

// File: rtl/router_switch_arbiter.sv
// rtl/router_switch_arbiter.sv - switch allocator with wormhole lock and stall watchdog
//   clk, rst_n            : clock, asynchronous active-low reset
//   i_in_valid_* / i_in_dest_* / i_in_tail_* : per-input flit present, route, last flit
//   i_out_ready_*         : per-output downstream ready
//   o_in_grant_*          : per-input flit consumed this cycle
//   o_control_*           : per-output selector code (00 none, 01 x, 10 y, 11 local)
//   o_issue               : sticky bad-destination flags per input
//   o_stall_err           : sticky watchdog flags per output
module router_switch_arbiter
    import router_pkg::*;
#(
    parameter int STALL_LIMIT = 16
)
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_in_valid_x,
    input  logic       i_in_valid_y,
    input  logic       i_in_valid_local,
    input  logic [1:0] i_in_dest_x,
    input  logic [1:0] i_in_dest_y,
    input  logic [1:0] i_in_dest_local,
    input  logic       i_in_tail_x,
    input  logic       i_in_tail_y,
    input  logic       i_in_tail_local,
    input  logic       i_out_ready_x,
    input  logic       i_out_ready_y,
    input  logic       i_out_ready_local,
    output logic       o_in_grant_x,
    output logic       o_in_grant_y,
    output logic       o_in_grant_local,
    output logic [1:0] o_control_x,
    output logic [1:0] o_control_y,
    output logic [1:0] o_control_local,
    output logic [2:0] o_issue,
    output logic [2:0] o_stall_err
);

    localparam int SW = (STALL_LIMIT > 0) ? $clog2(STALL_LIMIT + 1) : 1;
    localparam logic [SW-1:0] LIM_M1 = (STALL_LIMIT > 0) ? SW'(STALL_LIMIT - 1) : '0;

    logic [2:0]  w_valid, w_tail, w_ready, w_bad;
    logic [1:0]  w_dest [N_PORTS];

    out_state_e  r_state [N_PORTS];
    out_state_e  w_state_nxt [N_PORTS];
    logic [1:0]  r_owner [N_PORTS];
    logic [1:0]  w_owner_nxt [N_PORTS];
    logic [1:0]  r_ptr [N_PORTS];
    logic [1:0]  w_ptr_nxt [N_PORTS];
    logic [SW-1:0] r_cnt [N_PORTS];
    logic [SW-1:0] w_cnt_nxt [N_PORTS];
    logic [2:0]  r_issue, r_stall, w_stall_nxt;

    logic [2:0]  w_grant, w_xfer, w_done, w_owns, w_wd_fire, w_eligible;
    logic [2:0]  w_req [N_PORTS];
    logic [2:0]  w_arb_gnt [N_PORTS];
    logic [1:0]  w_arb_ptr [N_PORTS];
    logic [1:0]  w_ctrl [N_PORTS];

    assign w_valid   = {i_in_valid_local, i_in_valid_y, i_in_valid_x};
    assign w_tail    = {i_in_tail_local, i_in_tail_y, i_in_tail_x};
    assign w_ready   = {i_out_ready_local, i_out_ready_y, i_out_ready_x};
    assign w_dest[0] = i_in_dest_x;
    assign w_dest[1] = i_in_dest_y;
    assign w_dest[2] = i_in_dest_local;

    // Grants, per-output transfer status and arbitration requests.
    // A bad-dest flit is consumed unconditionally so it can never block its input.
    always_comb begin
        w_grant = '0;
        w_xfer  = '0;
        w_done  = '0;
        w_owns  = '0;
        w_bad   = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            w_bad[i] = w_valid[i] && (w_dest[i] == DIR_NONE);
            if (w_bad[i]) w_grant[i] = 1'b1;
        end
        for (int o = 0; o < N_PORTS; o++) begin
            if (r_state[o] == S_LOCKED) begin
                for (int i = 0; i < N_PORTS; i++) begin
                    if (r_owner[o] == idx_to_code(2'(i))) begin
                        w_owns[i] = 1'b1;
                        if (w_valid[i] && (w_dest[i] == idx_to_code(2'(o))) && w_ready[o]) begin
                            w_xfer[o]  = 1'b1;
                            w_grant[i] = 1'b1;
                            w_done[o]  = w_tail[i];
                        end
                    end
                end
            end
        end
        // Inputs holding any output (including one finishing its tail) do not compete.
        for (int o = 0; o < N_PORTS; o++) begin
            for (int i = 0; i < N_PORTS; i++) begin
                w_req[o][i] = w_valid[i] && (w_dest[i] == idx_to_code(2'(o))) && !w_owns[i];
            end
        end
    end

    for (genvar g = 0; g < N_PORTS; g++) begin : g_arb
        rr_arbiter3 u_arb (
            .i_req     (w_req[g]),
            .i_ptr     (r_ptr[g]),
            .o_gnt     (w_arb_gnt[g]),
            .o_nxt_ptr (w_arb_ptr[g])
        );
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int o = 0; o < N_PORTS; o++) begin
                r_state[o] <= S_FREE;
                r_owner[o] <= DIR_NONE;
                r_ptr[o]   <= 2'(PORT_X);
                r_cnt[o]   <= '0;
            end
            r_issue <= '0;
            r_stall <= '0;
        end else begin
            for (int o = 0; o < N_PORTS; o++) begin
                r_state[o] <= w_state_nxt[o];
                r_owner[o] <= w_owner_nxt[o];
                r_ptr[o]   <= w_ptr_nxt[o];
                r_cnt[o]   <= w_cnt_nxt[o];
            end
            r_issue <= r_issue | w_bad;
            r_stall <= w_stall_nxt;
        end
    end

    // Next state: watchdog release takes precedence; otherwise a free or
    // tail-completing output is handed to the round-robin winner.
    always_comb begin
        w_wd_fire   = '0;
        w_eligible  = '0;
        w_stall_nxt = r_stall;
        for (int o = 0; o < N_PORTS; o++) begin
            w_state_nxt[o] = r_state[o];
            w_owner_nxt[o] = r_owner[o];
            w_ptr_nxt[o]   = r_ptr[o];
            w_cnt_nxt[o]   = r_cnt[o];

            w_wd_fire[o]  = (STALL_LIMIT > 0) && (r_state[o] == S_LOCKED) &&
                            !w_xfer[o] && (r_cnt[o] == LIM_M1);
            w_eligible[o] = (r_state[o] == S_FREE) || w_done[o];

            if (r_state[o] == S_LOCKED) begin
                w_cnt_nxt[o] = w_xfer[o] ? '0 : r_cnt[o] + 1'b1;
            end

            if (w_wd_fire[o]) begin
                w_state_nxt[o] = S_FREE;
                w_owner_nxt[o] = DIR_NONE;
                w_cnt_nxt[o]   = '0;
                w_stall_nxt[o] = 1'b1;
            end else if (w_eligible[o]) begin
                w_cnt_nxt[o] = '0;
                if (|w_arb_gnt[o]) begin
                    w_state_nxt[o] = S_LOCKED;
                    w_owner_nxt[o] = onehot_to_code(w_arb_gnt[o]);
                    w_ptr_nxt[o]   = w_arb_ptr[o];
                end else begin
                    w_state_nxt[o] = S_FREE;
                    w_owner_nxt[o] = DIR_NONE;
                end
            end
        end
    end

    // Outputs
    always_comb begin
        for (int o = 0; o < N_PORTS; o++) begin
            w_ctrl[o] = (r_state[o] == S_LOCKED) ? r_owner[o] : DIR_NONE;
        end
    end

    assign o_control_x      = w_ctrl[PORT_X];
    assign o_control_y      = w_ctrl[PORT_Y];
    assign o_control_local  = w_ctrl[PORT_LOCAL];
    assign o_in_grant_x     = w_grant[PORT_X];
    assign o_in_grant_y     = w_grant[PORT_Y];
    assign o_in_grant_local = w_grant[PORT_LOCAL];
    assign o_issue          = r_issue;
    assign o_stall_err      = r_stall;

endmodule
